// File: rtl/hazard_controller.sv
// hazard_controller: stall / flush / forwarding sequencer for the 16-bit pipeline.
// Load-use hazards between decode and EX produce a single-cycle stall, taken
// branches produce a redirect pulse plus a FLUSH_CYCLES-long flush, and each
// decode operand gets an independent forwarding select. The stall and flush
// events are tallied in saturating counters.
module hazard_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_BITS     = 3,
    parameter int CNT_BITS     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dec_valid,
    input  logic [REG_BITS-1:0] dec_ra,
    input  logic                dec_ra_used,
    input  logic [REG_BITS-1:0] dec_rb,
    input  logic                dec_rb_used,
    input  logic                ex_valid,
    input  logic                ex_wr_en,
    input  logic                ex_is_load,
    input  logic [REG_BITS-1:0] ex_rt,
    input  logic                mem_valid,
    input  logic                mem_wr_en,
    input  logic [REG_BITS-1:0] mem_rt,
    input  logic                br_taken,
    input  logic [15:0]         br_target,
    output logic                stall,
    output logic                flush,
    output logic                redirect_valid,
    output logic [15:0]         redirect_pc,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [CNT_BITS-1:0] stall_count,
    output logic [CNT_BITS-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALLED = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    // Remaining FLUSH-state cycles after the branch cycle itself.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [2:0]          flush_left_r;
    logic [2:0]          flush_left_next_s;
    logic [15:0]         redirect_pc_r;
    logic [CNT_BITS-1:0] stall_count_r;
    logic [CNT_BITS-1:0] flush_count_r;

    logic ex_match_a_s, ex_match_b_s, mem_match_a_s, mem_match_b_s;
    logic lu_s;
    logic stall_s, flush_s, redirect_s;
    logic stall_inc_s, flush_inc_s;

    // Forwarding select for one operand: ALU result in EX wins over MEM;
    // a load in EX has no data yet, so it never forwards from EX.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                           input logic is_load);
        logic [1:0] sel;
        if (ex_hit && !is_load) begin
            sel = 2'b01;
        end else if (mem_hit) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign ex_match_a_s  = ex_valid  & ex_wr_en  & (ex_rt  == dec_ra);
    assign ex_match_b_s  = ex_valid  & ex_wr_en  & (ex_rt  == dec_rb);
    assign mem_match_a_s = mem_valid & mem_wr_en & (mem_rt == dec_ra);
    assign mem_match_b_s = mem_valid & mem_wr_en & (mem_rt == dec_rb);
    assign lu_s = dec_valid & ex_is_load &
                  ((dec_ra_used & ex_match_a_s) | (dec_rb_used & ex_match_b_s));

    // Next-state and control decode; all control outputs are held low in reset.
    always_comb begin
        stall_s           = 1'b0;
        flush_s           = 1'b0;
        redirect_s        = 1'b0;
        stall_inc_s       = 1'b0;
        flush_inc_s       = 1'b0;
        state_next_s      = state_r;
        flush_left_next_s = flush_left_r;
        if (reset) begin
            state_next_s      = ST_RUN;
            flush_left_next_s = 3'd0;
        end else begin
            case (state_r)
                ST_RUN, ST_STALLED: begin
                    if (br_taken) begin
                        // Branch wins over a coincident load-use hazard.
                        flush_s     = 1'b1;
                        redirect_s  = 1'b1;
                        flush_inc_s = 1'b1;
                        if (FLUSH_INIT == 3'd0) begin
                            state_next_s      = ST_RUN;
                            flush_left_next_s = 3'd0;
                        end else begin
                            state_next_s      = ST_FLUSH;
                            flush_left_next_s = FLUSH_INIT;
                        end
                    end else if (lu_s && (state_r == ST_RUN)) begin
                        // STALLED never re-stalls: the load has moved to MEM.
                        stall_s      = 1'b1;
                        stall_inc_s  = 1'b1;
                        state_next_s = ST_STALLED;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // Branch and hazard inputs refer to squashed instructions.
                    flush_s = 1'b1;
                    if (flush_left_r <= 3'd1) begin
                        state_next_s      = ST_RUN;
                        flush_left_next_s = 3'd0;
                    end else begin
                        state_next_s      = ST_FLUSH;
                        flush_left_next_s = flush_left_r - 3'd1;
                    end
                end
                default: begin
                    state_next_s      = ST_RUN;
                    flush_left_next_s = 3'd0;
                end
            endcase
        end
    end

    // State, flush countdown and redirect PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_RUN;
            flush_left_r  <= 3'd0;
            redirect_pc_r <= 16'd0;
        end else begin
            state_r      <= state_next_s;
            flush_left_r <= flush_left_next_s;
            if (redirect_s) begin
                redirect_pc_r <= br_target;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
        end
    end

    // Saturating stall/flush event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_r <= {CNT_BITS{1'b0}};
            flush_count_r <= {CNT_BITS{1'b0}};
        end else begin
            if (stall_inc_s && (stall_count_r != {CNT_BITS{1'b1}})) begin
                stall_count_r <= stall_count_r + CNT_BITS'(1);
            end
            if (flush_inc_s && (flush_count_r != {CNT_BITS{1'b1}})) begin
                flush_count_r <= flush_count_r + CNT_BITS'(1);
            end
        end
    end

    // Operand forwarding selects, independent of pipeline state.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (reset) begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end else begin
            fwd_a = fwd_sel(ex_match_a_s, mem_match_a_s, ex_is_load);
            fwd_b = fwd_sel(ex_match_b_s, mem_match_b_s, ex_is_load);
        end
    end

    assign stall          = stall_s;
    assign flush          = flush_s;
    assign redirect_valid = redirect_s;
    assign redirect_pc    = redirect_s ? br_target : redirect_pc_r;
    assign stall_count    = stall_count_r;
    assign flush_count    = flush_count_r;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scenarios followed by random traffic, every
// cycle compared against a cycle-level behavioural model of the controller.
module tb_hazard_controller;

    localparam int FC   = 2;
    localparam int RB   = 3;
    localparam int CB   = 4;
    localparam int CMAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          dec_valid, dec_ra_used, dec_rb_used;
    logic [RB-1:0] dec_ra, dec_rb, ex_rt, mem_rt;
    logic          ex_valid, ex_wr_en, ex_is_load, mem_valid, mem_wr_en, br_taken;
    logic [15:0]   br_target;
    logic          stall, flush, redirect_valid;
    logic [15:0]   redirect_pc;
    logic [1:0]    fwd_a, fwd_b;
    logic [CB-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    // Model state: remaining flush cycles, whether last cycle stalled,
    // unbounded event tallies and the last redirect address.
    int          m_flush_rem = 0;
    bit          m_prev_stall = 1'b0;
    int          m_stalls = 0;
    int          m_flushes = 0;
    logic [15:0] m_last_pc = 16'd0;

    hazard_controller #(.FLUSH_CYCLES(FC), .REG_BITS(RB), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_ra_used(dec_ra_used),
        .dec_rb(dec_rb), .dec_rb_used(dec_rb_used),
        .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rt(ex_rt),
        .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_rt(mem_rt),
        .br_taken(br_taken), .br_target(br_target),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ex_writes(input logic [RB-1:0] r);
        return ex_valid && ex_wr_en && (ex_rt == r);
    endfunction

    function automatic bit mem_writes(input logic [RB-1:0] r);
        return mem_valid && mem_wr_en && (mem_rt == r);
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [RB-1:0] r);
        if (reset) return 2'b00;
        if (ex_writes(r) && !ex_is_load) return 2'b01;
        if (mem_writes(r)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_in();
        reset = 1'b0; dec_valid = 1'b0; dec_ra = '0; dec_ra_used = 1'b0;
        dec_rb = '0; dec_rb_used = 1'b0; ex_valid = 1'b0; ex_wr_en = 1'b0;
        ex_is_load = 1'b0; ex_rt = '0; mem_valid = 1'b0; mem_wr_en = 1'b0;
        mem_rt = '0; br_taken = 1'b0; br_target = 16'd0;
    endtask

    // One clock: check outputs at the negedge, then advance the model at the posedge.
    task automatic step();
        bit hazard, e_stall, e_flush, e_rv;
        hazard = dec_valid && ex_is_load &&
                 ((dec_ra_used && ex_writes(dec_ra)) || (dec_rb_used && ex_writes(dec_rb)));
        e_stall = 1'b0; e_flush = 1'b0; e_rv = 1'b0;
        if (!reset) begin
            if (m_flush_rem > 0) begin
                e_flush = 1'b1;
            end else if (br_taken) begin
                e_flush = 1'b1;
                e_rv    = 1'b1;
            end else if (hazard && !m_prev_stall) begin
                e_stall = 1'b1;
            end
        end
        @(negedge clk);
        check_eq("stall", 32'(stall), 32'(e_stall));
        check_eq("flush", 32'(flush), 32'(e_flush));
        check_eq("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        check_eq("redirect_pc", 32'(redirect_pc), 32'(e_rv ? br_target : m_last_pc));
        check_eq("fwd_a", 32'(fwd_a), 32'(exp_fwd(dec_ra)));
        check_eq("fwd_b", 32'(fwd_b), 32'(exp_fwd(dec_rb)));
        check_eq("stall_count", 32'(stall_count), 32'((m_stalls > CMAX) ? CMAX : m_stalls));
        check_eq("flush_count", 32'(flush_count), 32'((m_flushes > CMAX) ? CMAX : m_flushes));
        @(posedge clk);
        if (reset) begin
            m_flush_rem = 0; m_prev_stall = 1'b0; m_stalls = 0; m_flushes = 0;
            m_last_pc = 16'd0;
        end else begin
            if (m_flush_rem > 0) begin
                m_flush_rem--;
            end else if (e_rv) begin
                m_flush_rem = FC - 1;
                m_flushes++;
                m_last_pc = br_target;
            end
            if (e_stall) m_stalls++;
            m_prev_stall = e_stall;
        end
        #1;
    endtask

    task automatic set_load_use(input logic [RB-1:0] r);
        ex_valid = 1'b1; ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rt = r;
        dec_valid = 1'b1; dec_ra = r; dec_ra_used = 1'b1;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();

        // Load-use on r3, then the load moves to MEM.
        set_load_use(3'd3);
        step();
        step();
        clear_in();
        mem_valid = 1'b1; mem_wr_en = 1'b1; mem_rt = 3'd3;
        dec_valid = 1'b1; dec_ra = 3'd3; dec_ra_used = 1'b1;
        step();

        // Persistent hazard for three cycles: 1,0,1.
        clear_in();
        set_load_use(3'd2);
        repeat (3) step();
        clear_in();
        step();

        // Taken branch, then a second br_taken pulse inside the flush window.
        br_taken = 1'b1; br_target = 16'h00A4;
        step();
        br_target = 16'h1234;
        step();
        clear_in();
        repeat (2) step();

        // Branch coincident with load-use.
        set_load_use(3'd1);
        br_taken = 1'b1; br_target = 16'h0F00;
        step();
        clear_in();
        repeat (2) step();

        // Forwarding priority: EX ALU over MEM, load in EX gives regfile.
        ex_valid = 1'b1; ex_wr_en = 1'b1; ex_rt = 3'd5;
        mem_valid = 1'b1; mem_wr_en = 1'b1; mem_rt = 3'd5;
        dec_valid = 1'b1; dec_rb = 3'd5; dec_rb_used = 1'b1;
        step();
        mem_valid = 1'b0; ex_is_load = 1'b1; dec_rb_used = 1'b0;
        step();
        clear_in();

        // Reset in the first flush cycle aborts the flush.
        br_taken = 1'b1; br_target = 16'h0040;
        step();
        clear_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (2) step();

        // Saturate stall_count with a long persistent hazard.
        set_load_use(3'd6);
        repeat (40) step();
        clear_in();
        step();

        // Random traffic with small register range to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_ra      = RB'($urandom_range(0, 3));
            dec_ra_used = $urandom_range(0, 1);
            dec_rb      = RB'($urandom_range(0, 3));
            dec_rb_used = $urandom_range(0, 1);
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_wr_en    = $urandom_range(0, 1);
            ex_is_load  = $urandom_range(0, 1);
            ex_rt       = RB'($urandom_range(0, 3));
            mem_valid   = $urandom_range(0, 1);
            mem_wr_en   = $urandom_range(0, 1);
            mem_rt      = RB'($urandom_range(0, 3));
            br_taken    = ($urandom_range(0, 7) == 0);
            br_target   = 16'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Sequences the 16-bit pipeline's stall and flush control. Detects load-use hazards between decode and EX, issues branch flush/redirect, and selects operand forwarding.
- Guarantees every stall pulse is exactly 1 cycle, which is the contract required by the fetch-side stall replay queue.
- Sits between decode/EX/MEM stage registers and the fetch unit. Drives the replay queue's stall/flush inputs.

Parameters:
- FLUSH_CYCLES, 2, total cycles flush is held after a taken branch (1..7)
- REG_BITS, 3, width of register index fields
- CNT_BITS, 16, width of saturating performance counters

Ports:
- clk  input  1  clock, all state on posedge
- reset  input  1  synchronous, active-high
- dec_valid  input  1  decode slot holds a real instruction
- dec_ra  input  REG_BITS  source A index
- dec_ra_used  input  1  instruction reads source A
- dec_rb  input  REG_BITS  source B index
- dec_rb_used  input  1  instruction reads source B
- ex_valid, ex_wr_en, ex_is_load  input  1 each  EX-stage instruction info
- ex_rt  input  REG_BITS  EX destination
- mem_valid, mem_wr_en  input  1 each  MEM-stage instruction info
- mem_rt  input  REG_BITS  MEM destination
- br_taken  input  1  EX resolved a taken branch/jump this cycle
- br_target  input  16  redirect address
- stall  output  1  hold fetch/decode one cycle
- flush  output  1  invalidate fetch/decode contents
- redirect_valid  output  1  single-cycle pulse, load PC
- redirect_pc  output  16  new PC, valid with redirect_valid
- fwd_a, fwd_b  output  2  00 = regfile, 01 = from EX, 10 = from MEM
- stall_count, flush_count  output  CNT_BITS  saturating event counters

Behaviour:
- State register (2 bits): RUN, STALLED, FLUSH.
- stall, flush, redirect_valid and fwd_* are combinational from inputs and state. Counters are registered.
- Terms:
  - exmatch(r) = ex_valid & ex_wr_en & ex_rt==r
  - memmatch(r) = mem_valid & mem_wr_en & mem_rt==r
  - lu = dec_valid & ex_is_load & ((dec_ra_used & exmatch(dec_ra)) | (dec_rb_used & exmatch(dec_rb)))
- RUN:
  - If br_taken: flush=1, redirect_valid=1, redirect_pc=br_target, stall=0.
    - Next state FLUSH with flush_left=FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES==1.
    - flush_count++.
  - Else if lu: stall=1, next STALLED, stall_count++.
  - Else: stall=0, flush=0, stay RUN.
- STALLED (exactly 1 cycle):
  - stall forced 0. The load is now in MEM, so the hazard resolves via forwarding.
  - If br_taken: same as RUN branch handling.
  - Else next RUN.
  - Back-to-back stall is impossible by construction.
- FLUSH:
  - flush=1, stall=0, redirect_valid=0.
  - br_taken and lu are ignored, because EX/decode contents are flushed.
  - flush_left decrements each cycle. Move to RUN when flush_left reaches 0 at the clock edge.
- Forwarding (all states), independent per operand:
  - fwd_x=01 if exmatch(src) & !ex_is_load.
  - Else 10 if memmatch(src).
  - Else 00.
  - EX has priority over MEM. A load in EX never yields 01.
- redirect_pc = br_target whenever redirect_valid=1. It holds its last redirect value otherwise (registered copy). Reset value 0.
- Counters saturate at all-ones and never wrap.
- Reset (takes priority over all events):
  - state=RUN, flush_left=0, counters=0, redirect_pc=0.
  - stall, flush, redirect_valid and fwd_* are forced 0 while reset=1.
  - Reset mid-FLUSH or mid-STALLED aborts the sequence immediately. First cycle after reset is RUN.
- Simultaneous br_taken and lu in RUN: branch wins, no stall, stall_count unchanged.

Test Plan:
- Load-use: EX load r3 (wr_en), decode reads ra=3 -> stall=1 for 1 cycle, state STALLED, next cycle stall=0, stall_count=1. Then MEM r3 with no EX writer of r3 -> fwd_a=10.
- Persistent hazard inputs held 3 cycles -> stall pattern 1,0,1. Never two consecutive 1s; stall_count=2.
- Taken branch br_target=0x00A4, FLUSH_CYCLES=2 -> flush=1 for 2 cycles, redirect_valid 1 then 0, redirect_pc=0x00A4, flush_count=1. br_taken pulse during 2nd flush cycle is ignored.
- Branch + load-use same cycle -> flush=1, stall=0, stall_count=0, flush_count=1.
- Forwarding priority:
  - EX (ALU) and MEM both write r5, decode rb=5 used -> fwd_b=01.
  - EX is a load of r5 and lu is inactive because rb_used=0 -> fwd_b=00.
- Reset asserted in 1st FLUSH cycle -> next cycle flush=0, state RUN, counters 0. Forcing stall_count to saturate (CNT_BITS=4, 16 hazards) -> stays 0xF.
